// File: rtl/prog_loader_pkg.sv
// Shared types and helpers for the program loader.
package prog_loader_pkg;

  // Loader state; ST_CHECK is only reachable when PROG_LOADER_CHECKSUM_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_SETTLE,
    ST_RUN,
    ST_ERR
  } state_t;

  // Width of the settle down-counter (RUN_DELAY range is 1..15).
  localparam int unsigned DELAY_W = 4;

  // Width needed to hold a word count of 0..max_words inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Program-word stream: valid/ready handshake carrying one word plus end-of-image marker.
interface prog_loader_if #(
  parameter int unsigned DATA_W = 32
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/prog_loader_addr_gen.sv
// Write-address pointer with fixed stride and image word counter with capacity flag.
module prog_loader_addr_gen
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned MAX_WORDS = 128,
  localparam int unsigned CNT_W    = cnt_width(MAX_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] ptr,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              full
);

  // Pointer and count restart on a new load and step once per written word; pointer wraps silently.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr      <= ADDR_W'(BASE_ADDR);
      word_cnt <= '0;
    end else if (clear) begin
      ptr      <= ADDR_W'(BASE_ADDR);
      word_cnt <= '0;
    end else if (advance) begin
      ptr      <= ptr + ADDR_W'(ADDR_STEP);
      word_cnt <= word_cnt + CNT_W'(1);
    end
  end

  assign full = (word_cnt == CNT_W'(MAX_WORDS));

endmodule

// File: rtl/prog_loader.sv
// Streams a program image into instruction memory and releases the core PC after a settle delay.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (trailing checksum word verified before run).
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned MAX_WORDS = 128,
  parameter int unsigned RUN_DELAY = 2,
  localparam int unsigned CNT_W    = cnt_width(MAX_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  prog_loader_if.slave      strm,
  output logic              we0,
  output logic [ADDR_W-1:0] wr_addr0,
  output logic [DATA_W-1:0] wr_din0,
  output logic              resetpc,
  output logic              busy,
  output logic              error,
  output logic [CNT_W-1:0]  word_cnt
);

  // Counter starts one below RUN_DELAY so resetpc rises RUN_DELAY cycles after the final we0 cycle.
  localparam logic [DELAY_W-1:0] DLY_INIT = DELAY_W'(RUN_DELAY - 1);

  state_t               state;
  logic                 ready;
  logic [DELAY_W-1:0]   dly;
  logic [ADDR_W-1:0]    ptr;
  logic                 full;
  logic                 accept;
  logic                 restart;
  logic                 advance;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]    sum;
`endif

  assign strm.s_ready = ready;

  // Handshake qualification and pointer control derived from the current state.
  always_comb begin
    accept  = strm.s_valid && ready;
    restart = start && ((state == ST_IDLE) || (state == ST_RUN) || (state == ST_ERR));
    advance = accept && (state == ST_LOAD) && !full;
  end

  prog_loader_addr_gen #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR),
    .ADDR_STEP(ADDR_STEP),
    .MAX_WORDS(MAX_WORDS)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (restart),
    .advance (advance),
    .ptr     (ptr),
    .word_cnt(word_cnt),
    .full    (full)
  );

  // Loader FSM with registered handshake, write-port and status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      ready    <= 1'b0;
      we0      <= 1'b0;
      wr_addr0 <= ADDR_W'(BASE_ADDR);
      wr_din0  <= '0;
      resetpc  <= 1'b0;
      busy     <= 1'b0;
      error    <= 1'b0;
      dly      <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum      <= '0;
`endif
    end else begin
      we0 <= 1'b0;
      case (state)
        ST_IDLE, ST_RUN, ST_ERR: begin
          if (start) begin
            state   <= ST_LOAD;
            ready   <= 1'b1;
            busy    <= 1'b1;
            resetpc <= 1'b0;
            error   <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum     <= '0;
`endif
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (full) begin
              // One word beyond capacity: drop it and stop.
              state <= ST_ERR;
              ready <= 1'b0;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              we0      <= 1'b1;
              wr_addr0 <= ptr;
              wr_din0  <= strm.s_data;
`ifdef PROG_LOADER_CHECKSUM_EN
              sum      <= sum + strm.s_data;
              if (strm.s_last) state <= ST_CHECK;
`else
              if (strm.s_last) begin
                state <= ST_SETTLE;
                ready <= 1'b0;
                dly   <= DLY_INIT;
              end
`endif
            end
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept) begin
            ready <= 1'b0;
            if (strm.s_data == sum) begin
              state <= ST_SETTLE;
              dly   <= DLY_INIT;
            end else begin
              state <= ST_ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end
          end
        end
`endif
        ST_SETTLE: begin
          if (dly == '0) begin
            state   <= ST_RUN;
            resetpc <= 1'b1;
            busy    <= 1'b0;
          end else begin
            dly <= dly - DELAY_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader; follows PROG_LOADER_CHECKSUM_EN when defined.
module tb_prog_loader;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned BASE_ADDR = 40;
  localparam int unsigned ADDR_STEP = 4;
  localparam int unsigned MAX_WORDS = 12;
  localparam int unsigned RUN_DELAY = 3;
  localparam int unsigned CNT_W     = 4;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk   = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              we0;
  logic [ADDR_W-1:0] wr_addr0;
  logic [DATA_W-1:0] wr_din0;
  logic              resetpc;
  logic              busy;
  logic              error;
  logic [CNT_W-1:0]  word_cnt;

  prog_loader_if #(.DATA_W(DATA_W)) strm();

  prog_loader #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE_ADDR),
    .ADDR_STEP(ADDR_STEP),
    .MAX_WORDS(MAX_WORDS),
    .RUN_DELAY(RUN_DELAY)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .strm    (strm),
    .we0     (we0),
    .wr_addr0(wr_addr0),
    .wr_din0 (wr_din0),
    .resetpc (resetpc),
    .busy    (busy),
    .error   (error),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;
  wr_t exp_q[$];
  wr_t mon_e;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Byte address of image word i: base plus stride, wrapped to the address width.
  function automatic logic [ADDR_W-1:0] addr_of(input int i);
    int unsigned a;
    a = (BASE_ADDR + ADDR_STEP * i) % (1 << ADDR_W);
    return a[ADDR_W-1:0];
  endfunction

  // Monitor: every write must match the oldest expected write and occur while busy.
  always @(negedge clk) begin
    if (we0 === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none", wr_addr0, wr_din0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr0", 64'(wr_addr0), 64'(mon_e.addr));
        chk("wr_din0", 64'(wr_din0), 64'(mon_e.data));
      end
      chk("we0_while_busy", 64'(busy), 64'd1);
    end
  end

  // One load: start pulse, n words (s_last on word n if last), optional checksum, abort after abort_at words.
  task automatic run_load(input int n, input bit last, input bit gaps, input bit fixed_data,
                          input bit bad_sum, input int abort_at);
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] sum;
    bit v;
    bit exp_err;
    int i;
    int budget;
    int total;
    int final_cyc;
    int exp_cnt;

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_resetpc", 64'(resetpc), 64'd0);
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_ready", 64'(strm.s_ready), 64'd1);
    chk("start_error", 64'(error), 64'd0);
    chk("start_word_cnt", 64'(word_cnt), 64'd0);

    total     = n + ((CSUM && last && n <= int'(MAX_WORDS)) ? 1 : 0);
    sum       = '0;
    i         = 0;
    budget    = 0;
    final_cyc = 0;
    while (i < total && i != abort_at) begin
      @(negedge clk);
      budget++;
      if (budget > 500) begin
        bound_fail("load_accept");
        break;
      end
      v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (i < n) w = fixed_data ? DATA_W'(32'h13 + i) : DATA_W'($urandom);
      else       w = (bad_sum && CSUM) ? sum + 1 : sum;
      strm.s_valid = v;
      strm.s_data  = w;
      strm.s_last  = last && (i == n - 1);
      if (v && strm.s_ready) begin
        if (i < n) begin
          sum += w;
          if (i < int'(MAX_WORDS)) exp_q.push_back('{addr: addr_of(i), data: w});
        end
        final_cyc = cyc + 1;
        i++;
      end
    end
    @(negedge clk);
    strm.s_valid = 1'b0;
    strm.s_last  = 1'b0;
    if (i == abort_at) return;

    exp_err = (n > int'(MAX_WORDS)) || (bad_sum && CSUM);
    exp_cnt = (n > int'(MAX_WORDS)) ? int'(MAX_WORDS) : n;
    if (exp_err) begin
      repeat (4) @(negedge clk);
      chk("err_error", 64'(error), 64'd1);
      chk("err_resetpc", 64'(resetpc), 64'd0);
    end else begin
      budget = 0;
      while (resetpc !== 1'b1 && budget < 64) begin
        @(negedge clk);
        budget++;
      end
      if (resetpc !== 1'b1) bound_fail("resetpc_rise");
      else chk("resetpc_delay", 64'(cyc - final_cyc), 64'(RUN_DELAY));
      chk("run_error", 64'(error), 64'd0);
    end
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_ready", 64'(strm.s_ready), 64'd0);
    chk("done_word_cnt", 64'(word_cnt), 64'(exp_cnt));
    chk("writes_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    strm.s_valid = 1'b0;
    strm.s_data  = '0;
    strm.s_last  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_we0", 64'(we0), 64'd0);
    chk("rst_wr_addr0", 64'(wr_addr0), 64'(BASE_ADDR));
    chk("rst_wr_din0", 64'(wr_din0), 64'd0);
    chk("rst_resetpc", 64'(resetpc), 64'd0);
    chk("rst_ready", 64'(strm.s_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_word_cnt", 64'(word_cnt), 64'd0);
    reset = 1'b1;

    // 10-word image 0x13..0x1C back to back, then again with random valid gaps (restart from RUN).
    run_load(10, 1'b1, 1'b0, 1'b1, 1'b0, -1);
    run_load(10, 1'b1, 1'b1, 1'b1, 1'b0, -1);

    // s_valid in RUN is ignored: no writes, core keeps running.
    strm.s_valid = 1'b1;
    strm.s_data  = DATA_W'($urandom);
    repeat (5) @(negedge clk);
    strm.s_valid = 1'b0;
    chk("run_ignores_resetpc", 64'(resetpc), 64'd1);
    chk("run_ignores_word_cnt", 64'(word_cnt), 64'd10);

    // Exactly capacity with s_last is legal; one beyond capacity without s_last is an error.
    run_load(int'(MAX_WORDS), 1'b1, 1'b1, 1'b0, 1'b0, -1);
    run_load(int'(MAX_WORDS) + 1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
    run_load(2, 1'b1, 1'b0, 1'b0, 1'b0, -1);

    // Reset after the third word of a 10-word load, then a fresh load from the base address.
    run_load(10, 1'b1, 1'b0, 1'b0, 1'b0, 3);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_we0", 64'(we0), 64'd0);
    chk("midrst_resetpc", 64'(resetpc), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(strm.s_ready), 64'd0);
    chk("midrst_word_cnt", 64'(word_cnt), 64'd0);
    chk("midrst_pending", 64'(exp_q.size()), 64'd0);
    reset = 1'b1;
    run_load(5, 1'b1, 1'b1, 1'b0, 1'b0, -1);

    // Image {1,2,3}-style short load with a corrupted checksum (plain load when checksum is off).
    run_load(3, 1'b1, 1'b0, 1'b0, 1'b1, -1);

    // Randomized lengths and gaps.
    for (int k = 0; k < 6; k++)
      run_load(int'($urandom_range(1, MAX_WORDS)), 1'b1, ($urandom_range(0, 1) == 1),
               1'b0, 1'b0, -1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
